// File: rtl/jserial_alu_pkg.sv
// jserial_alu_pkg: shared opcodes and FSM state encoding for the bit-serial ALU.
package jserial_alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_CMP = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/jserial_alu_jbitslice.sv
// jbitslice: one-bit ADD/CMP slice built from primitive gate cells, plus those cells.
module jxor (input logic a, input logic b, output logic y);
  assign y = a ^ b;
endmodule

module jand (input logic a, input logic b, output logic y);
  assign y = a & b;
endmodule

module jor (input logic a, input logic b, output logic y);
  assign y = a | b;
endmodule

module jnot (input logic a, output logic y);
  assign y = ~a;
endmodule

module jbitslice (
  input  logic a,
  input  logic b,
  input  logic carry,
  input  logic eq,
  input  logic al,
  output logic sum,
  output logic xo,
  output logic carry_next,
  output logic eq_next,
  output logic al_next
);
  logic cx, ab, nx, ea, eax;
  jxor u_x0 (.a(a),     .b(b),     .y(xo));
  jxor u_x1 (.a(xo),    .b(carry), .y(sum));
  jand u_a0 (.a(carry), .b(xo),    .y(cx));
  jand u_a1 (.a(a),     .b(b),     .y(ab));
  jor  u_o0 (.a(cx),    .b(ab),    .y(carry_next));
  jnot u_n0 (.a(xo),    .y(nx));
  jand u_a2 (.a(eq),    .b(nx),    .y(eq_next));
  // A wins at the first differing bit (MSB first) only while still equal above it
  jand u_a3 (.a(eq),    .b(a),     .y(ea));
  jand u_a4 (.a(ea),    .b(xo),    .y(eax));
  jor  u_o1 (.a(al),    .b(eax),   .y(al_next));
endmodule

// File: rtl/jserial_alu.sv
// jserial_alu: bit-serial ADD/CMP sequencer stepping one shared slice over N bits.
module jserial_alu
  import jserial_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         wstart,
  input  logic         wop,
  input  logic [N-1:0] wa,
  input  logic [N-1:0] wb,
  input  logic         wci,
  output logic         wbusy,
  output logic         wdone,
  output logic [N-1:0] wc,
  output logic         wco,
  output logic         weq,
  output logic         wal
);
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KMAX = KW'(N - 1);
  state_t state, state_n;
  logic [KW-1:0] k, i;
  logic [N-1:0] ra, rb, c;
  logic rop, carry, eq, al;
  logic sum, xo, carry_next, eq_next, al_next;
  // ADD walks LSB first, CMP walks MSB first
  assign i = rop == OP_CMP ? KMAX - k : k;
  jbitslice u_slice (
    .a(ra[i]), .b(rb[i]), .carry(carry), .eq(eq), .al(al),
    .sum(sum), .xo(xo), .carry_next(carry_next), .eq_next(eq_next), .al_next(al_next)
  );
  always_comb begin
    state_n = state == S_IDLE ? (wstart ? S_RUN : S_IDLE) :
              state == S_RUN  ? (k == KMAX ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= S_IDLE;
      k     <= '0;
      ra    <= '0;
      rb    <= '0;
      rop   <= OP_ADD;
      c     <= '0;
      carry <= 1'b0;
      eq    <= 1'b0;
      al    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && wstart) begin
        ra    <= wa;
        rb    <= wb;
        rop   <= wop;
        k     <= '0;
        c     <= '0;
        carry <= wop == OP_ADD ? wci : 1'b0;
        eq    <= wop == OP_CMP;
        al    <= 1'b0;
      end else if (state == S_RUN) begin
        c[i]  <= rop == OP_CMP ? xo : sum;
        carry <= rop == OP_ADD ? carry_next : carry;
        eq    <= eq_next;
        al    <= al_next;
        k     <= k == KMAX ? k : k + 1'b1;
      end
    end
  end
  assign wbusy = state != S_IDLE;
  assign wdone = state == S_DONE;
  assign wc    = c;
  assign wco   = rop == OP_ADD & carry;
  assign weq   = rop == OP_CMP & eq;
  assign wal   = rop == OP_CMP & al;
endmodule

// File: tb/tb_jserial_alu.sv
// tb_jserial_alu: directed scoreboard bench for the bit-serial ALU sequencer.
module tb_jserial_alu;
  localparam int N = 8;
  typedef struct packed {
    logic [N-1:0] c;
    logic co;
    logic eq;
    logic al;
  } res_t;
  logic wclk = 1'b0, wrst_n = 1'b0, wstart = 1'b0, wop = 1'b0, wci = 1'b0;
  logic [N-1:0] wa = '0, wb = '0;
  logic wbusy, wdone, wco, weq, wal;
  logic [N-1:0] wc;
  res_t q[$];
  int total = 0, bad = 0;

  always #5 wclk = ~wclk;

  jserial_alu #(.N(N)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wstart(wstart), .wop(wop), .wa(wa), .wb(wb), .wci(wci),
    .wbusy(wbusy), .wdone(wdone), .wc(wc), .wco(wco), .weq(weq), .wal(wal)
  );

  function automatic res_t model(input logic op, input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    res_t r;
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    r.c  = op ? a ^ b : s[N-1:0];
    r.co = op ? 1'b0 : s[N];
    r.eq = op ? (a == b) : 1'b0;
    r.al = op ? (a > b) : 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, "_c"}, 32'(wc), 32'(e.c));
    chk({tag, "_co"}, 32'(wco), 32'(e.co));
    chk({tag, "_eq"}, 32'(weq), 32'(e.eq));
    chk({tag, "_al"}, 32'(wal), 32'(e.al));
  endtask

  // Drive a request, push its expected result, return at the negedge after the accepting edge
  task automatic start(input logic op, input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input bit hold);
    wop = op; wa = a; wb = b; wci = ci; wstart = 1'b1;
    q.push_back(model(op, a, b, ci));
    @(posedge wclk);
    @(negedge wclk);
    if (!hold) wstart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    int cnt = 0;
    res_t e;
    while (!wdone && cnt < N + 8) begin
      @(posedge wclk);
      @(negedge wclk);
      cnt++;
    end
    if (exp_edges >= 0) chk({tag, "_latency"}, 32'(cnt), 32'(exp_edges));
    chk({tag, "_done"}, 32'(wdone), 32'd1);
    chk({tag, "_busy"}, 32'(wbusy), 32'd1);
    if (q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = q.pop_front();
      check_res(tag, e);
      @(posedge wclk);
      @(negedge wclk);
      chk({tag, "_pulse"}, 32'(wdone), 32'd0);
      chk({tag, "_idle"}, 32'(wbusy), 32'd0);
      check_res({tag, "_hold"}, e);
    end
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge wclk);
    check_res("rst", '0);
    chk("rst_busy", 32'(wbusy), 32'd0);
    chk("rst_done", 32'(wdone), 32'd0);
    wrst_n = 1'b1;
    @(negedge wclk);
    start(1'b0, 8'h3C, 8'h0F, 1'b0, 0);
    wait_done("add0", N);
    start(1'b0, 8'hFF, 8'h01, 1'b0, 0);
    wait_done("add_wrap", N);
    start(1'b0, 8'h7F, 8'h00, 1'b1, 0);
    wait_done("add_ci", N);
    start(1'b1, 8'h80, 8'h7F, 1'b0, 0);
    wait_done("cmp_gt", N);
    start(1'b1, 8'h5A, 8'h5A, 1'b1, 0);
    wait_done("cmp_eq", N);
    start(1'b1, 8'h10, 8'h11, 1'b0, 0);
    wait_done("cmp_lt", N);
    // New request pulsed in mid-run must be dropped
    start(1'b0, 8'h21, 8'h34, 1'b1, 0);
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wop = 1'b1; wa = 8'hAA; wb = 8'h55; wci = 1'b0; wstart = 1'b1;
    @(posedge wclk);
    @(negedge wclk);
    wstart = 1'b0;
    wait_done("busy_ign", N - 4);
    // wstart held through DONE is taken on the first IDLE edge
    start(1'b1, 8'hC3, 8'hC4, 1'b0, 1);
    wop = 1'b0; wa = 8'h99; wb = 8'h88; wci = 1'b1;
    q.push_back(model(1'b0, 8'h99, 8'h88, 1'b1));
    wait_done("hold1", N);
    @(posedge wclk);
    @(negedge wclk);
    wstart = 1'b0;
    wait_done("hold2", N);
    // Abort mid-run with reset
    start(1'b0, 8'h55, 8'h22, 1'b0, 0);
    void'(q.pop_back());
    repeat (4) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    check_res("abort", '0);
    chk("abort_busy", 32'(wbusy), 32'd0);
    chk("abort_done", 32'(wdone), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 4) begin
      @(negedge wclk);
      if (wdone) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    start(1'b0, 8'h01, 8'h01, 1'b0, 0);
    wait_done("post_rst", N);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
